ascon_mem_stream: RTL

//  Parametrised memory sequencer between the 32-bit scratch RAM and the ASCON permutation core.

---
 rtl/ascon_mem_stream.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ascon_mem_stream.sv
`default_nettype none
// ============================================================================
// Module  : ascon_mem_stream
// Brief   : Sequencer that streams message blocks from the scratch RAM to the
//           ASCON core, then writes the returned blocks back to RAM.
// Revision: 1.0 - initial release
// ============================================================================
module ascon_mem_stream #(
  parameter  int CORE_W = 64,
  parameter  int MEM_W  = 32,
  parameter  int ADDR_W = 5,
  parameter  int LEN_W  = 8,
  localparam int WPB    = CORE_W / MEM_W,
  localparam int BPB    = CORE_W / 8,
  localparam int BS_W   = $clog2(BPB + 1)
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              busy,
  input  logic              ct_valid,
  input  logic [LEN_W-1:0]  datalen,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [MEM_W-1:0]  wb_wdata,
  input  logic [MEM_W-1:0]  mem_rdata,
  input  logic [CORE_W-1:0] core_din,
  output logic [CORE_W-1:0] core_dout,
  output logic              pt_valid,
  output logic [BS_W-1:0]   blocksize,
  output logic              we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MEM_W-1:0]  mem_wdata,
  output logic              wb_stall,
  output logic              done
);

  localparam int IDX_W = $clog2(WPB + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [LEN_W-1:0]   r_blk;
  logic [LEN_W-1:0]   r_remain;
  logic [IDX_W-1:0]   r_idx;
  logic [ADDR_W-1:0]  r_src;
  logic [ADDR_W-1:0]  r_dst;
  logic [CORE_W-1:0]  r_rd_buf;
  logic [CORE_W-1:0]  r_wr_buf;
  logic               w_last;
  logic [ADDR_W-1:0]  w_blk_off;
  logic [MEM_W-1:0]   w_wr_word;

  // r_remain counts bytes left including the current block
  assign w_last    = (int'(r_remain) <= BPB);
  assign w_blk_off = ADDR_W'(int'(r_blk) * WPB);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (busy) w_next = (datalen == '0) ? S_DONE : S_READ;
      S_READ:  if (!busy) w_next = S_IDLE;
               else if (r_idx == IDX_W'(WPB)) w_next = S_WAIT;
      S_WAIT:  if (!busy) w_next = S_IDLE;
               else if (ct_valid) w_next = S_WRITE;
      S_WRITE: if (!busy) w_next = S_IDLE;
               else if (r_idx == IDX_W'(WPB - 1)) w_next = w_last ? S_DONE : S_READ;
      S_DONE:  if (!busy) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_blk    <= '0;
      r_remain <= '0;
      r_idx    <= '0;
      r_src    <= '0;
      r_dst    <= '0;
      r_rd_buf <= '0;
      r_wr_buf <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (busy) begin
          r_src    <= src_base;
          r_dst    <= dst_base;
          r_remain <= datalen;
          r_blk    <= '0;
          r_idx    <= '0;
        end
        S_READ: if (busy) begin
          // RAM data lags the address by one cycle, so word idx-1 lands now
          for (int w = 0; w < WPB; w++)
            if (r_idx == IDX_W'(w + 1)) r_rd_buf[w*MEM_W +: MEM_W] <= mem_rdata;
          r_idx <= (r_idx == IDX_W'(WPB)) ? '0 : r_idx + 1'b1;
        end
        S_WAIT: if (busy && ct_valid) begin
          r_wr_buf <= core_din;
          r_idx    <= '0;
        end
        S_WRITE: if (busy) begin
          if (r_idx == IDX_W'(WPB - 1)) begin
            r_idx <= '0;
            if (!w_last) begin
              r_blk    <= r_blk + 1'b1;
              r_remain <= r_remain - LEN_W'(BPB);
            end
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_wr_word = '0;
    for (int w = 0; w < WPB; w++)
      if (r_idx == IDX_W'(w)) w_wr_word = r_wr_buf[w*MEM_W +: MEM_W];
  end

  always_comb begin
    we        = 1'b1;
    mem_addr  = r_src + w_blk_off + ADDR_W'(r_idx);
    mem_wdata = '0;
    case (r_state)
      S_IDLE: begin
        we        = wb_we;
        mem_addr  = wb_addr;
        mem_wdata = wb_wdata;
      end
      S_WRITE: begin
        we        = 1'b0;
        mem_addr  = r_dst + w_blk_off + ADDR_W'(r_idx);
        mem_wdata = w_wr_word;
      end
      default: ;
    endcase
  end

  assign core_dout = r_rd_buf;
  assign pt_valid  = (r_state == S_WAIT);
  assign blocksize = ((r_state == S_WAIT) || (r_state == S_WRITE))
                     ? (w_last ? BS_W'(r_remain) : BS_W'(BPB)) : '0;
  assign wb_stall  = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule
`default_nettype wire
